// File: rtl/comparador_pkg.sv
// comparador_pkg: state encoding, result codes and slice width shared by the sequential comparator.
package comparador_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    RESULT  = 2'b10
  } state_t;
  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;
  localparam int SLICE_W = 2;
  function automatic logic [1:0] res_of(input logic gt, input logic lt);
    return gt ? RES_GT : lt ? RES_LT : RES_EQ;
  endfunction
endpackage

// File: rtl/comparador_slice.sv
// comparador_slice: combinational 2-bit unsigned compare; equality is implied when gt and lt are both low.
module comparador_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       lt
);
  assign gt = a > b;
  assign lt = a < b;
endmodule

// File: rtl/comparador_secuencial.sv
// comparador_secuencial: MSB-first magnitude compare, one 2-bit slice per clock, start/ready/done handshake.
// COMPARADOR_EARLY_EXIT_EN stops at the first differing slice; otherwise all slices are always scanned.
module comparador_secuencial
  import comparador_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic             READY,
  output logic             DONE,
  output logic             GT,
  output logic             EQ,
  output logic             LT
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       res_q, res_d;
  logic             valid_q, valid_d;
  logic             sgt, slt, last;
  comparador_slice u_slice (
    .a  (a_q[idx_q*SLICE_W +: SLICE_W]),
    .b  (b_q[idx_q*SLICE_W +: SLICE_W]),
    .gt (sgt),
    .lt (slt)
  );
  assign last = idx_q == '0;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (START) begin
        a_d     = A_IN;
        b_d     = B_IN;
        idx_d   = IW'(NSLICE - 1);
        res_d   = RES_EQ;
        valid_d = 1'b0;
        state_d = COMPARE;
      end
      COMPARE: begin
`ifdef COMPARADOR_EARLY_EXIT_EN
        res_d = res_of(sgt, slt);
        if (sgt || slt || last) begin
          valid_d = 1'b1;
          state_d = RESULT;
        end else idx_d = idx_q - 1'b1;
`else
        // res_q leaves RES_EQ only once, so the most significant difference sticks
        if (res_q == RES_EQ) res_d = res_of(sgt, slt);
        if (last) begin
          valid_d = 1'b1;
          state_d = RESULT;
        end else idx_d = idx_q - 1'b1;
`endif
      end
      RESULT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= IW'(NSLICE - 1);
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= RES_EQ;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end
  assign READY = state_q == IDLE;
  assign DONE  = state_q == RESULT;
  assign GT    = valid_q && res_q == RES_GT;
  assign EQ    = valid_q && res_q == RES_EQ;
  assign LT    = valid_q && res_q == RES_LT;
endmodule

// File: tb/tb_comparador_secuencial.sv
// tb_comparador_secuencial: directed vectors with a result/latency scoreboard drained by a DONE monitor.
module tb_comparador_secuencial;
  logic       CLK = 1'b0, RST = 1'b1, START = 1'b0;
  logic [7:0] A_IN = '0, B_IN = '0;
  logic       READY, DONE, GT, EQ, LT;
  int         tests = 0, fails = 0, cyc = 0;
  typedef struct {
    logic [2:0] r;
    int         due;
  } exp_t;
  exp_t sb[$];
  localparam logic [2:0] R_GT = 3'b100, R_EQ = 3'b010, R_LT = 3'b001;

  comparador_secuencial #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A_IN(A_IN), .B_IN(B_IN),
    .READY(READY), .DONE(DONE), .GT(GT), .EQ(EQ), .LT(LT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int lat(input int n);
`ifdef COMPARADOR_EARLY_EXIT_EN
    return n;
`else
    return 4;
`endif
  endfunction

  always @(negedge CLK) if (DONE) begin
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL spurious_done: DONE at cycle %0d with nothing pending", cyc);
    end else begin
      exp_t e;
      e = sb.pop_front();
      if ({GT, EQ, LT} !== e.r || cyc != e.due) begin
        fails++;
        $display("FAIL result: got GT/EQ/LT=%b at cycle %0d, want %b at cycle %0d",
                 {GT, EQ, LT}, cyc, e.r, e.due);
      end
    end
  end

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: READY/DONE/GT/EQ/LT got %b want %b", name, got, want);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] r, input int n);
    int k;
    k = 0;
    while (!READY && k < 20) begin @(negedge CLK); k++; end
    A_IN = a; B_IN = b; START = 1'b1;
    sb.push_back('{r, cyc + 1 + lat(n)});
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!DONE && k < 20) begin @(negedge CLK); k++; end
    tests++;
    if (!DONE) begin
      fails++;
      $display("FAIL %s_timeout: DONE got 0 want 1", name);
    end
  endtask

  task automatic run(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] r, input int n);
    @(negedge CLK);
    issue(a, b, r, n);
    @(negedge CLK);
    START = 1'b0;
    wait_done(name);
    @(negedge CLK);
    check({name, "_after"}, {READY, DONE, GT, EQ, LT}, {2'b10, r});
  endtask

  initial begin
    START = 1'b1; A_IN = 8'hFF; B_IN = 8'h00;
    repeat (2) @(negedge CLK);
    check("reset", {READY, DONE, GT, EQ, LT}, 5'b10000);
    RST = 1'b0; START = 1'b0;
    @(negedge CLK);
    check("reset_no_capture", {READY, DONE, GT, EQ, LT}, 5'b10000);

    run("c3_43", 8'hC3, 8'h43, R_GT, 1);
    run("5a_5a", 8'h5A, 8'h5A, R_EQ, 4);
    run("12_13", 8'h12, 8'h13, R_LT, 4);
    run("00_ff", 8'h00, 8'hFF, R_LT, 1);
    run("ff_fe", 8'hFF, 8'hFE, R_GT, 4);
    run("00_00", 8'h00, 8'h00, R_EQ, 4);

    // START held and A_IN changed while busy: one result, no re-accept
    @(negedge CLK);
    issue(8'h80, 8'h40, R_GT, 1);
    @(negedge CLK);
    A_IN = 8'h00;
    begin
      int k;
      k = 0;
      while (!DONE && k < 20) begin check("hold_busy", {READY, DONE}, 2'b00); @(negedge CLK); k++; end
    end
    wait_done("hold");
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("hold_after", {READY, DONE, GT, EQ, LT}, {2'b10, R_GT});

    // reset mid-compare discards the pending result
    @(negedge CLK);
    A_IN = 8'h5A; B_IN = 8'h5A; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("abort_busy", {READY, DONE}, 2'b00);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_reset", {READY, DONE, GT, EQ, LT}, 5'b10000);
    repeat (4) @(negedge CLK);
    check("abort_quiet", {READY, DONE, GT, EQ, LT}, 5'b10000);
    run("01_02", 8'h01, 8'h02, R_LT, 4);

    repeat (3) @(negedge CLK);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comparador_secuencial.md
Name: comparador_secuencial

Overview:
- Sequential magnitude-comparison controller for two unsigned WIDTH-bit operands.
- Scans the operands MSB-first in 2-bit slices, two bits per clock, using one shared 2-bit compare slice.
- Reports greater, equal or less through a start/ready/done handshake.
- Sits between any requester needing an N-bit compare and the 2-bit comparator datapath; it sequences that datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be even and ≥2.
- NSLICE, WIDTH/2, derived number of 2-bit slices; not overridable.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  request; sampled only while READY=1.
- A_IN  in  WIDTH  operand A; captured on the accepted START edge.
- B_IN  in  WIDTH  operand B; captured on the accepted START edge.
- READY  out  1  high in IDLE only.
- DONE  out  1  one-cycle pulse; result valid.
- GT  out  1  A>B.
- EQ  out  1  A==B.
- LT  out  1  A<B.

Behaviour:
- Interface decided: one clock CLK; RST synchronous, active-high.
- Reset values: state=IDLE, READY=1, DONE=0, GT=EQ=LT=0, slice index=NSLICE-1, operand registers=0.
- States:
  - IDLE: READY=1. START=1 captures A_IN/B_IN, loads idx=NSLICE-1, clears GT/EQ/LT, goes to COMPARE.
  - COMPARE: READY=0. Each edge compares slice A[2idx+1:2idx] vs B[2idx+1:2idx].
    - Slices unequal: register GT/LT from the slice, go to RESULT.
    - Slices equal and idx==0: set EQ=1, go to RESULT.
    - Otherwise: idx decrements.
  - RESULT: DONE=1 for exactly one cycle, then IDLE.
- Outputs GT/EQ/LT are held after RESULT until the next accepted START, which clears them.
- Exactly one of GT/EQ/LT is high whenever DONE=1.
- Latency: with n slices examined, DONE is high in the cycle after the n-th rising edge following the START-accepting edge.
  - n ranges 1..NSLICE.
  - READY returns 1 one cycle after DONE.
- START while READY=0 (COMPARE or RESULT): ignored; not queued.
- Operand inputs changing after capture: no effect on the result.
- RST during COMPARE or RESULT: immediate return to reset values; no DONE pulse; the pending result is discarded.
- RST and START in the same cycle: RST wins.

Optional Feature:
- Macro: COMPARADOR_EARLY_EXIT_EN.
- Defined: COMPARE exits on the first unequal slice (variable latency, as above).
- Undefined: all NSLICE slices are always scanned, giving fixed latency NSLICE.
  - A sticky "decided" flag freezes GT/LT at the first (most significant) unequal slice.
  - EQ=1 only if no slice differed.
- Function is identical in both builds; only latency differs.

Decomposition:
- Package comparador_pkg holds:
  - State encoding constants: IDLE=2'b00, COMPARE=2'b01, RESULT=2'b10.
  - Result code constants: RES_EQ=2'b00, RES_GT=2'b01, RES_LT=2'b10.
  - Slice width constant SLICE_W=2.
- Sub-module comparador_slice: combinational 2-bit unsigned compare (inputs a[1:0], b[1:0]; outputs gt, lt; eq is implied when both are low).
  - Instantiated once; fed by the idx-selected operand bits.

Test Plan:
- Reset: RST=1 for 2 cycles, START=1 throughout → READY=1, DONE=0, GT=EQ=LT=0; no capture occurs.
- A_IN=0xC3, B_IN=0x43, START pulse:
  - EARLY_EXIT_EN defined → DONE after 1 edge, GT=1.
  - Undefined → DONE after 4 edges, GT=1.
- A_IN=0x5A, B_IN=0x5A → DONE after 4 edges, EQ=1, GT=LT=0; READY=1 the next cycle.
- A_IN=0x12, B_IN=0x13 → last slice decides; DONE after 4 edges, LT=1.
- Start 0x80 vs 0x40; hold START=1 and change A_IN to 0x00 during COMPARE → exactly one DONE, GT=1, no second request accepted.
- Start 0x5A vs 0x5A; assert RST after 2 edges → no DONE, outputs 0, READY=1; a subsequent 0x01 vs 0x02 gives LT=1.
